branch_resolution_unit: RTL

- Consumes the ALU zero flag with the EX-stage branch decode and resolves beq/bne.
- On a taken branch, issues a registered PC redirect to fetch using a valid/ready handshake.
- Flushes the wrong-path IF/ID instructions and stalls EX until the redirect completes.
- Sits between the EX stage (zero flag generator, branch target adder) and the PC/fetch unit.

---
 rtl/branch_resolution_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_resolution_unit.sv
// Resolves EX-stage beq/bne and issues a registered PC redirect, then flushes IF/ID.
// Optional saturating branch statistics are enabled with the BRU_STATS_EN macro.
module branch_resolution_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_bne,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              pc_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              stall_ex,
  output logic [STAT_W-1:0] taken_count,
  output logic [STAT_W-1:0] branch_count
);

  // state    | meaning
  // S_IDLE   | evaluating EX branches each cycle
  // S_REDIR  | redirect_valid held until fetch accepts it
  // S_FLUSH  | squashing IF/ID for FLUSH_CYCLES cycles
  typedef enum logic [1:0] {S_IDLE, S_REDIR, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       branch_seen;
  logic       take;

  assign branch_seen = ex_valid & ex_branch;
  // The flag terms are masked by branch_seen, so X on them never reaches state.
  assign take        = branch_seen & (zero ^ ex_bne);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      stall_ex       <= 1'b0;
      flush_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            redirect_pc    <= branch_target;
            redirect_valid <= 1'b1;
            stall_ex       <= 1'b1;
            state          <= S_REDIR;
          end
        end
        S_REDIR: begin
          if (pc_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            flush_cnt      <= FLUSH_INIT;
            state          <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
          end else begin
            flush    <= 1'b0;
            stall_ex <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          stall_ex       <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BRU_STATS_EN
  logic [STAT_W-1:0] taken_q;
  logic [STAT_W-1:0] branch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q  <= '0;
      branch_q <= '0;
    end else if (state == S_IDLE) begin
      if (branch_seen && !(&branch_q)) branch_q <= branch_q + 1'b1;
      if (take && !(&taken_q))         taken_q  <= taken_q + 1'b1;
    end
  end

  assign taken_count  = taken_q;
  assign branch_count = branch_q;
`else
  assign taken_count  = '0;
  assign branch_count = '0;
`endif

endmodule
